// File: rtl/reg_file_bank_if.sv
// Request/response bundle for the register bank: one write port, two read ports.
interface reg_file_bank_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 5
);
   logic             WRITE;
   logic [AW-1:0]    ADDR_W;
   logic [WIDTH-1:0] DATA_W;
   logic             READ;
   logic [AW-1:0]    ADDR_R1;
   logic [AW-1:0]    ADDR_R2;
   logic [WIDTH-1:0] DATA_R1;
   logic [WIDTH-1:0] DATA_R2;

   modport master (
      output WRITE, ADDR_W, DATA_W, READ, ADDR_R1, ADDR_R2,
      input  DATA_R1, DATA_R2
   );

   modport slave (
      input  WRITE, ADDR_W, DATA_W, READ, ADDR_R1, ADDR_R2,
      output DATA_R1, DATA_R2
   );
endinterface

// File: rtl/reg_file_bank.sv
// Register bank: DEPTH x WIDTH flops, one write port, two registered read
// ports with write-first bypass and an optional hard-wired zero entry.
module reg_file_bank #(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      DEPTH     = 32,
   parameter int unsigned      AW        = (DEPTH > 2) ? $clog2(DEPTH) : 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               ZERO_REG  = 1'b1
) (
   input  logic            CLK,
   input  logic            RST,
   reg_file_bank_if.slave  bus
);

   // One extra bit so DEPTH == 2**AW is representable for range checks.
   localparam int unsigned AWP     = AW + 1;
   localparam logic [AW:0] DEPTH_C = AWP'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] rd1_q, rd1_d;
   logic [WIDTH-1:0] rd2_q, rd2_d;
   logic             wr_ok_c;

   // A write lands only when in range and not aimed at the zero entry.
   always_comb begin
      wr_ok_c = bus.WRITE && ({1'b0, bus.ADDR_W} < DEPTH_C)
                && !(ZERO_REG && (bus.ADDR_W == '0));
   end

   // Next array contents.
   always_comb begin
      mem_d = mem_q;
      if (wr_ok_c) mem_d[bus.ADDR_W] = bus.DATA_W;
   end

   // Port 1 read mux with write-first bypass; invalid addresses read 0.
   always_comb begin
      rd1_d = '0;
      if (({1'b0, bus.ADDR_R1} < DEPTH_C) && !(ZERO_REG && (bus.ADDR_R1 == '0))) begin
         if (wr_ok_c && (bus.ADDR_R1 == bus.ADDR_W)) rd1_d = bus.DATA_W;
         else                                        rd1_d = mem_q[bus.ADDR_R1];
      end
   end

   // Port 2 read mux, identical to port 1.
   always_comb begin
      rd2_d = '0;
      if (({1'b0, bus.ADDR_R2} < DEPTH_C) && !(ZERO_REG && (bus.ADDR_R2 == '0))) begin
         if (wr_ok_c && (bus.ADDR_R2 == bus.ADDR_W)) rd2_d = bus.DATA_W;
         else                                        rd2_d = mem_q[bus.ADDR_R2];
      end
   end

   // Array and read registers; reset wins over any coincident access.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VAL;
         end
         rd1_q <= '0;
         rd2_q <= '0;
      end else begin
         mem_q <= mem_d;
         if (bus.READ) begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
         end
      end
   end

   assign bus.DATA_R1 = rd1_q;
   assign bus.DATA_R2 = rd2_q;

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed checks of reg_file_bank (GPR configuration) plus a model-checked
// random sweep on a small bank without a zero entry.
module tb_reg_file_bank;

   localparam logic [31:0] RV_A = 32'hA5A5_0000;
   localparam logic [7:0]  RV_B = 8'h3C;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   reg_file_bank_if #(.WIDTH(32), .AW(5)) if_a ();
   reg_file_bank_if #(.WIDTH(8),  .AW(3)) if_b ();

   reg_file_bank #(.WIDTH(32), .DEPTH(24), .AW(5), .RESET_VAL(RV_A), .ZERO_REG(1'b1))
      u_dut_a (.CLK(clk), .RST(rst_a), .bus(if_a));

   reg_file_bank #(.WIDTH(8), .DEPTH(5), .AW(3), .RESET_VAL(RV_B), .ZERO_REG(1'b0))
      u_dut_b (.CLK(clk), .RST(rst_b), .bus(if_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_a [24];
   logic [7:0]  m_b [5];
   logic [7:0]  e1, e2;

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      if_a.WRITE = 0; if_a.ADDR_W = '0; if_a.DATA_W = '0;
      if_a.READ = 0; if_a.ADDR_R1 = '0; if_a.ADDR_R2 = '0;
      if_b.WRITE = 0; if_b.ADDR_W = '0; if_b.DATA_W = '0;
      if_b.READ = 0; if_b.ADDR_R1 = '0; if_b.ADDR_R2 = '0;
      tick();
      rst_a = 1'b0; rst_b = 1'b0;

      // Reset: outputs cleared, entry 0 zero, others RESET_VAL
      chk("rst_r1", if_a.DATA_R1, 32'h0);
      chk("rst_r2", if_a.DATA_R2, 32'h0);
      if_a.READ = 1; if_a.ADDR_R1 = 5'd0; if_a.ADDR_R2 = 5'd5;
      tick();
      chk("rst_rd0", if_a.DATA_R1, 32'h0);
      chk("rst_rd5", if_a.DATA_R2, RV_A);
      if_a.READ = 0;

      // Basic write/read and hold
      if_a.WRITE = 1; if_a.ADDR_W = 5'd3; if_a.DATA_W = 32'd24;
      tick();
      if_a.ADDR_W = 5'd7; if_a.DATA_W = 32'd13;
      tick();
      if_a.WRITE = 0;
      if_a.READ = 1; if_a.ADDR_R1 = 5'd3; if_a.ADDR_R2 = 5'd7;
      tick();
      chk("rd_a3", if_a.DATA_R1, 32'd24);
      chk("rd_a7", if_a.DATA_R2, 32'd13);
      if_a.READ = 0; if_a.ADDR_R1 = 5'd5; if_a.ADDR_R2 = 5'd0;
      tick();
      chk("hold1_r1", if_a.DATA_R1, 32'd24);
      chk("hold1_r2", if_a.DATA_R2, 32'd13);
      tick();
      chk("hold2_r1", if_a.DATA_R1, 32'd24);
      chk("hold2_r2", if_a.DATA_R2, 32'd13);

      // Write-first bypass
      if_a.WRITE = 1; if_a.ADDR_W = 5'd9; if_a.DATA_W = 32'd9;
      if_a.READ = 1; if_a.ADDR_R1 = 5'd9; if_a.ADDR_R2 = 5'd9;
      tick();
      chk("byp_r1", if_a.DATA_R1, 32'd9);
      chk("byp_r2", if_a.DATA_R2, 32'd9);
      if_a.WRITE = 0; if_a.ADDR_R2 = 5'd3;
      tick();
      chk("byp_after", if_a.DATA_R1, 32'd9);
      chk("byp_r2_a3", if_a.DATA_R2, 32'd24);

      // Zero entry and out-of-range writes are dropped, no bypass
      if_a.READ = 0;
      if_a.WRITE = 1; if_a.ADDR_W = 5'd0; if_a.DATA_W = 32'hFFFF_FFFF;
      tick();
      if_a.ADDR_W = 5'd30;
      if_a.READ = 1; if_a.ADDR_R1 = 5'd30; if_a.ADDR_R2 = 5'd0;
      tick();
      chk("oor_byp", if_a.DATA_R1, 32'h0);
      chk("zero_rd", if_a.DATA_R2, 32'h0);
      if_a.WRITE = 0;
      if_a.ADDR_R1 = 5'd0; if_a.ADDR_R2 = 5'd30;
      tick();
      chk("zero_rd2", if_a.DATA_R1, 32'h0);
      chk("oor_rd2", if_a.DATA_R2, 32'h0);

      // Full sweep: nothing else moved (30 must not alias onto 6 or 14)
      for (int i = 0; i < 24; i++) exp_a[i] = (i == 0) ? 32'h0 : RV_A;
      exp_a[3] = 32'd24; exp_a[7] = 32'd13; exp_a[9] = 32'd9;
      for (int i = 0; i < 24; i++) begin
         if_a.ADDR_R1 = 5'(i); if_a.ADDR_R2 = 5'(23 - i);
         tick();
         chk($sformatf("sweep_r1_%0d", i), if_a.DATA_R1, exp_a[i]);
         chk($sformatf("sweep_r2_%0d", 23 - i), if_a.DATA_R2, exp_a[23 - i]);
      end

      // Reset beats coincident write and read
      rst_a = 1;
      if_a.WRITE = 1; if_a.ADDR_W = 5'd4; if_a.DATA_W = 32'd77;
      if_a.READ = 1; if_a.ADDR_R1 = 5'd4; if_a.ADDR_R2 = 5'd3;
      tick();
      rst_a = 0; if_a.WRITE = 0;
      chk("rstw_r1", if_a.DATA_R1, 32'h0);
      chk("rstw_r2", if_a.DATA_R2, 32'h0);
      tick();
      chk("rstw_a4", if_a.DATA_R1, RV_A);
      chk("rstw_a3", if_a.DATA_R2, RV_A);
      if_a.READ = 0;

      // Small bank, entry 0 writable
      for (int i = 0; i < 5; i++) m_b[i] = RV_B;
      e1 = 8'h0; e2 = 8'h0;
      if_b.WRITE = 1; if_b.ADDR_W = 3'd0; if_b.DATA_W = 8'h5A;
      tick();
      m_b[0] = 8'h5A;
      if_b.WRITE = 0; if_b.READ = 1; if_b.ADDR_R1 = 3'd0; if_b.ADDR_R2 = 3'd4;
      tick();
      chk("b_e0", 32'(if_b.DATA_R1), 32'h5A);
      chk("b_e4", 32'(if_b.DATA_R2), 32'(RV_B));
      e1 = 8'h5A; e2 = RV_B;

      // Random sweep against a behavioural model
      for (int c = 0; c < 1000; c++) begin
         if_b.WRITE   = 1'($urandom_range(1, 0));
         if_b.READ    = 1'($urandom_range(1, 0));
         if_b.ADDR_W  = 3'($urandom_range(7, 0));
         if_b.ADDR_R1 = 3'($urandom_range(7, 0));
         if_b.ADDR_R2 = 3'($urandom_range(7, 0));
         if_b.DATA_W  = 8'($urandom_range(255, 0));
         if (if_b.WRITE && (if_b.ADDR_W < 3'd5)) m_b[if_b.ADDR_W] = if_b.DATA_W;
         if (if_b.READ) begin
            e1 = (if_b.ADDR_R1 < 3'd5) ? m_b[if_b.ADDR_R1] : 8'h0;
            e2 = (if_b.ADDR_R2 < 3'd5) ? m_b[if_b.ADDR_R2] : 8'h0;
         end
         tick();
         chk($sformatf("rnd_r1_%0d", c), 32'(if_b.DATA_R1), 32'(e1));
         chk($sformatf("rnd_r2_%0d", c), 32'(if_b.DATA_R2), 32'(e2));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reg_file_bank.md
# reg_file_bank

Parametrised multi-port register bank, the successor to the single 32-bit load register. It holds DEPTH words of WIDTH bits with one synchronous write port and two registered read ports. An optional hard-wired zero entry makes it a drop-in CPU general-purpose register file for the processor datapath. Reset initialises every entry to a programmable value.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 32, number of entries (≥2; need not be a power of two)
- AW, clog2(DEPTH), address width (derived; minimum 1)
- RESET_VAL, 0, value loaded into every entry on reset (WIDTH bits)
- ZERO_REG, 1, when 1, entry 0 always reads 0 and ignores writes

- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, synchronous, active-high
- WRITE  in  1  write enable
- ADDR_W  in  AW  write address
- DATA_W  in  WIDTH  write data
- READ  in  1  read enable for both read ports
- ADDR_R1  in  AW  read port 1 address
- ADDR_R2  in  AW  read port 2 address
- DATA_R1  out  WIDTH  read port 1 data (registered)
- DATA_R2  out  WIDTH  read port 2 data (registered)

## Operation
- Storage: DEPTH × WIDTH flop array; no combinational path from the array to the outputs.
- Reset (RST=1 at an edge): every entry ← RESET_VAL. With ZERO_REG=1, entry 0 ← 0 regardless of RESET_VAL. DATA_R1 and DATA_R2 ← 0. RST overrides WRITE and READ in the same cycle.
- Write (WRITE=1, RST=0): entry[ADDR_W] ← DATA_W at the edge.
  - ZERO_REG=1 and ADDR_W=0: write is dropped.
  - ADDR_W ≥ DEPTH: write is dropped; no entry is modified and there is no aliasing.
- Read (READ=1, RST=0): at the edge, DATA_Rn ← entry[ADDR_Rn] for each port independently.
  - READ=0: DATA_R1 and DATA_R2 hold their previous values.
  - ADDR_Rn ≥ DEPTH reads 0.
  - ZERO_REG=1 and ADDR_Rn=0 reads 0.
- Simultaneous write and read at the same valid address: write-first. DATA_Rn receives DATA_W in that cycle (internal bypass), and the entry holds DATA_W afterwards.
  - Bypass is suppressed when the write itself is dropped (zero register or out of range).
- Both read ports may use the same address; both return identical data.
- X or Z on inputs is not a supported condition; no recovery is required.

## Timing
- Write latency: one edge. Data written at edge N is visible to a read issued at edge N (via bypass) or at any later edge.
- Read latency: one edge. Address and READ are sampled at edge N; DATA_Rn is valid after edge N and stable until the next edge with READ=1 or RST=1.
- Reset latency: one edge. Outputs are 0 and the array holds RESET_VAL after the first edge with RST=1.
- Reset mid-operation: a WRITE or READ coincident with RST is discarded entirely.
- Throughput: one write plus two reads per cycle, with no stalls and no handshake beyond the enables.
- Critical path: read mux (DEPTH:1) plus bypass compare; this must meet a single cycle at WIDTH=32, DEPTH=32.

## Test plan
1. **Reset.** RESET_VAL=32'hA5A5_0000, ZERO_REG=1. Pulse RST for one edge, then read addresses 0 and 5.
   - Required: DATA_R1=0, DATA_R2=32'hA5A5_0000. Outputs are 0 immediately after reset.
2. **Basic write/read and hold.** Write 24 to addr 3, then 13 to addr 7. READ with ADDR_R1=3, ADDR_R2=7, then drop READ for 2 cycles.
   - Required: DATA_R1=24 and DATA_R2=13 one edge after READ; both hold while READ=0.
3. **Write-first bypass.** WRITE=1, ADDR_W=9, DATA_W=9, with READ=1, ADDR_R1=9 on the same edge.
   - Required: DATA_R1=9 after that edge, and a following read of addr 9 returns 9.
4. **Zero register and out-of-range.** DEPTH=24. Write 32'hFFFF_FFFF to addr 0 and to addr 30, then read addr 0 and addr 30.
   - Required: both reads return 0, and no entry 0–23 changes (verified by full sweep).
5. **Reset beats write.** RST=1 and WRITE=1 (addr 4, data 77) on the same edge, then read addr 4.
   - Required: read returns RESET_VAL, not 77.
6. **Randomised sweep.** 1000 cycles of random WRITE/READ/addresses/data against a behavioural model, with WIDTH=8, DEPTH=5, ZERO_REG=0.
   - Required: zero mismatches, and entry 0 is writable.
